// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC parallel-bus write sequencer.
package rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR_SU,
    S_ADR_PW,
    S_ADR_HD,
    S_DAT_SU,
    S_DAT_PW,
    S_DAT_HD,
    S_DONE
  } wr_state_t;

  localparam int T_SU_DEF = 2;
  localparam int T_PW_DEF = 4;
  localparam int T_HD_DEF = 2;

  localparam logic [7:0] RTC_ADDR_SEC   = 8'h00;
  localparam logic [7:0] RTC_ADDR_MIN   = 8'h01;
  localparam logic [7:0] RTC_ADDR_HOUR  = 8'h02;
  localparam logic [7:0] RTC_ADDR_WDAY  = 8'h03;
  localparam logic [7:0] RTC_ADDR_DATE  = 8'h04;
  localparam logic [7:0] RTC_ADDR_MONTH = 8'h05;
  localparam logic [7:0] RTC_ADDR_YEAR  = 8'h06;

  // A phase of N cycles loads N-1 so that expiry lands on the phase's last cycle.
  function automatic logic [7:0] phase_load(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/rtc_wr_seq_phase_timer.sv
// Loadable 8-bit down-counter that parks at zero; expired is high while the count is zero.
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       expired
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= 8'd0;
    end else if (load) begin
      value <= load_value;
    end else if (value != 8'd0) begin
      value <= value - 8'd1;
    end
  end

  assign expired = (value == 8'd0);

endmodule

// File: rtl/rtc_wr_seq.sv
// RTC write sequencer: address phase then data phase on a shared AD bus, each with setup/pulse/hold timing.
// Optional sticky overlap-error output enabled by defining RTC_WR_ERR_EN.
//
//   state  | meaning
//   IDLE   | bus released, waiting for start
//   ADR_SU | address driven, cs_n low, wr_n high
//   ADR_PW | address driven, wr_n low
//   ADR_HD | address held, cs_n/wr_n released
//   DAT_SU | data driven, cs_n low, wr_n high
//   DAT_PW | data driven, wr_n low
//   DAT_HD | data held, cs_n/wr_n released
//   DONE   | one-cycle completion pulse
module rtc_wr_seq
  import rtc_pkg::*;
#(
  parameter int T_SU = T_SU_DEF,
  parameter int T_PW = T_PW_DEF,
  parameter int T_HD = T_HD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       addr_sel,
  output logic       ad_oe,
  output logic [7:0] ad_out
`ifdef RTC_WR_ERR_EN
  ,
  output logic       err
`endif
);

  wr_state_t  state, state_nxt;
  logic [7:0] addr_q, data_q, addr_nxt, data_nxt;
  logic       cap_en;
  logic       tmr_load, tmr_expired;
  logic [7:0] tmr_load_val;
  logic [7:0] tmr_value_unused;

  logic       busy_nxt, done_nxt, cs_n_nxt, wr_n_nxt, addr_sel_nxt, ad_oe_nxt;
  logic [7:0] ad_out_nxt;

  phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_val),
    .value      (tmr_value_unused),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      addr_q <= 8'h00;
      data_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cap_en       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = 8'h00;
    case (state)
      S_IDLE: if (start) begin
        state_nxt    = S_ADR_SU;
        cap_en       = 1'b1;
        tmr_load     = 1'b1;
        tmr_load_val = phase_load(T_SU);
      end
      S_ADR_SU: if (tmr_expired) begin
        state_nxt    = S_ADR_PW;
        tmr_load     = 1'b1;
        tmr_load_val = phase_load(T_PW);
      end
      S_ADR_PW: if (tmr_expired) begin
        state_nxt    = S_ADR_HD;
        tmr_load     = 1'b1;
        tmr_load_val = phase_load(T_HD);
      end
      S_ADR_HD: if (tmr_expired) begin
        state_nxt    = S_DAT_SU;
        tmr_load     = 1'b1;
        tmr_load_val = phase_load(T_SU);
      end
      S_DAT_SU: if (tmr_expired) begin
        state_nxt    = S_DAT_PW;
        tmr_load     = 1'b1;
        tmr_load_val = phase_load(T_PW);
      end
      S_DAT_PW: if (tmr_expired) begin
        state_nxt    = S_DAT_HD;
        tmr_load     = 1'b1;
        tmr_load_val = phase_load(T_HD);
      end
      S_DAT_HD: if (tmr_expired) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign addr_nxt = cap_en ? addr : addr_q;
  assign data_nxt = cap_en ? data : data_q;

  // Outputs are decoded from the next state so the registered pins line up with the state they describe.
  always_comb begin
    busy_nxt     = (state_nxt != S_IDLE);
    done_nxt     = (state_nxt == S_DONE);
    cs_n_nxt     = 1'b1;
    wr_n_nxt     = 1'b1;
    addr_sel_nxt = 1'b0;
    ad_oe_nxt    = 1'b0;
    ad_out_nxt   = 8'h00;
    case (state_nxt)
      S_ADR_SU, S_ADR_PW, S_ADR_HD: begin
        cs_n_nxt     = (state_nxt == S_ADR_HD);
        wr_n_nxt     = (state_nxt != S_ADR_PW);
        addr_sel_nxt = 1'b1;
        ad_oe_nxt    = 1'b1;
        ad_out_nxt   = addr_nxt;
      end
      S_DAT_SU, S_DAT_PW, S_DAT_HD: begin
        cs_n_nxt   = (state_nxt == S_DAT_HD);
        wr_n_nxt   = (state_nxt != S_DAT_PW);
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = data_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      addr_sel <= 1'b0;
      ad_oe    <= 1'b0;
      ad_out   <= 8'h00;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      cs_n     <= cs_n_nxt;
      wr_n     <= wr_n_nxt;
      addr_sel <= addr_sel_nxt;
      ad_oe    <= ad_oe_nxt;
      ad_out   <= ad_out_nxt;
    end
  end

  assign rd_n = 1'b1;

`ifdef RTC_WR_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (start && busy) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/rtc_wr_seq.md
RTC_WR_SEQ -- requirements
Module: rtc_wr_seq

Interface
REQ-001 Parameter T_SU, default 2, address/data setup cycles before strobe; legal range 1..255.
REQ-002 Parameter T_PW, default 4, wr_n low-pulse cycles; legal range 1..255.
REQ-003 Parameter T_HD, default 2, hold cycles after strobe release; legal range 1..255.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle write request; sampled only in IDLE.
REQ-007 addr  input  8  RTC register address, captured with start.
REQ-008 data  input  8  BCD write data, captured with start.
REQ-009 busy  output  1  high from the cycle after an accepted start through DONE.
REQ-010 done  output  1  one-cycle pulse in DONE state.
REQ-011 cs_n  output  1  RTC chip select, active-low.
REQ-012 wr_n  output  1  RTC write strobe, active-low.
REQ-013 rd_n  output  1  RTC read strobe; held 1 by this block.
REQ-014 addr_sel  output  1  1 = address phase on bus, 0 = data phase.
REQ-015 ad_oe  output  1  tristate enable for the shared AD bus.
REQ-016 ad_out  output  8  value driven onto AD bus.

Function
REQ-017 FSM states: IDLE, ADR_SU, ADR_PW, ADR_HD, DAT_SU, DAT_PW, DAT_HD, DONE; each timed state lasts exactly its parameter count, via a down-counter loaded on entry.
REQ-018 IDLE + start=1 -> capture addr/data, next state ADR_SU; start=0 -> stay IDLE.
REQ-019 ADR_SU: cs_n=0, wr_n=1, addr_sel=1, ad_oe=1, ad_out=captured addr.
REQ-020 ADR_PW: as ADR_SU but wr_n=0.
REQ-021 ADR_HD: cs_n=1, wr_n=1, addr_sel=1, ad_oe=1, ad_out=captured addr.
REQ-022 DAT_SU/DAT_PW/DAT_HD: same pattern as address phase with addr_sel=0, ad_out=captured data.
REQ-023 DAT_HD exit -> DONE for exactly one cycle: done=1, busy=1, bus idle values; then IDLE.
REQ-024 Latency: start at edge k -> done high in cycle k+1+2*(T_SU+T_PW+T_HD); defaults give done in cycle k+17.
REQ-025 start while busy=1 (including DONE) is ignored; captured addr/data unchanged.
REQ-026 IDLE outputs: cs_n=1, wr_n=1, rd_n=1, addr_sel=0, ad_oe=0, ad_out=0, busy=0, done=0.
REQ-027 wr_n SHALL never be 0 while cs_n=1; ad_out SHALL not change while wr_n=0.
REQ-028 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset=1 at any edge, including mid-transfer, forces IDLE, all outputs to REQ-026 values, counter and captured registers to 0; no done pulse for the aborted transfer.
REQ-030 reset has priority over start in the same cycle.

Configuration
REQ-031 RTC_WR_ERR_EN defined: extra output err (1 bit), set sticky when start=1 while busy=1, cleared only by reset.
REQ-032 RTC_WR_ERR_EN undefined: no err port, overlapping start silently ignored per REQ-025.

Structure
REQ-033 Package rtc_pkg holds the state enum, default T_SU/T_PW/T_HD constants and the RTC address constants for seconds..year registers.
REQ-034 One sub-module phase_timer: 8-bit loadable down-counter with load, value and expired outputs.

Verification
REQ-035 Defaults, start with addr=0x24, data=0x15 -> ADR_SU 2 cycles ad_out=0x24 addr_sel=1, wr_n low 4 cycles, hold 2; data phase ad_out=0x15 addr_sel=0; done in cycle k+17.
REQ-036 T_SU=1,T_PW=1,T_HD=1 -> done at cycle k+7; wr_n low exactly 1 cycle per phase.
REQ-037 Second start (addr=0x25) in ADR_PW -> ignored, transfer completes with 0x24/0x15; with RTC_WR_ERR_EN err=1 until reset.
REQ-038 reset asserted during DAT_PW -> next cycle cs_n=1, wr_n=1, ad_oe=0, busy=0; no done pulse.
REQ-039 Back-to-back: start in the cycle after done -> accepted, new transfer identical timing.
REQ-040 Assertion over all runs: wr_n=0 implies cs_n=0, ad_oe=1, ad_out stable; rd_n always 1.
